alu_result_collector: RTL
=========================

// Module: alu_result_collector
// PURPOSE
//   Downstream stage of the ALU execution units (arithmetic, logic, compare, shift).
//   Each cycle, picks the one valid unit result, tags it with a source ID and buffers it in a FIFO.
//   Results are returned to the consumer (register file / UART TX framer) over a valid/ready handshake.
//   Counts collisions and overflow drops for debug.
// PARAMETERS
//   A_WIDTH     16  operand A width of upstream units
//   B_WIDTH     16  operand B width; result width OUT_W = A_WIDTH + B_WIDTH
//   FIFO_DEPTH  4   result entries; power of 2, >= 2
//   CNT_WIDTH   8   width of the drop and collision counters
// PORTS
//   clk            in   1               clock, rising edge
//   rst            in   1               asynchronous, active-low reset
//   Arith_OUT      in   OUT_W           arithmetic unit result
//   Arith_Flag     in   1               arithmetic result valid, one-cycle pulse
//   Logic_OUT      in   OUT_W           logic unit result
//   Logic_Flag     in   1               logic result valid, one-cycle pulse
//   CMP_OUT        in   OUT_W           compare unit result
//   CMP_Flag       in   1               compare result valid
//   SHIFT_OUT      in   OUT_W           shift unit result
//   SHIFT_Flag     in   1               shift result valid
//   res_valid      out  1               FIFO head valid (= not empty)
//   res_ready      in   1               consumer accepts head
//   res_data       out  OUT_W           head result
//   res_src        out  2               head source: 0 arith, 1 logic, 2 cmp, 3 shift
//   fill_level     out  log2(DEPTH)+1   current occupancy
//   drop_cnt       out  CNT_WIDTH       results lost to a full FIFO, saturating
//   collision_cnt  out  CNT_WIDTH       cycles with >1 flag high, saturating
// BEHAVIOUR
//   - Reset (rst low, async):
//       res_valid=0, res_data=0, res_src=0, fill_level=0, drop_cnt=0, collision_cnt=0.
//       Pointers cleared; the contents of any in-flight entry are discarded.
//   - Unit outputs are registered, so OUT and Flag are sampled on the same clk edge.
//   - Select: fixed priority arith > logic > cmp > shift. Only the winner is a push candidate.
//   - Collision: >1 flag high in a cycle -> collision_cnt += 1 (saturates at all-ones).
//       Losers are discarded.
//   - push = any flag high and (not full or pop in the same cycle).
//   - pop  = res_valid && res_ready.
//   - Push writes {src, data} at wr_ptr.
//       Latency: a flag at edge N gives res_valid=1 with that data after edge N (1 cycle).
//   - Full, push wanted, no pop -> entry dropped, drop_cnt += 1 (saturating), FIFO unchanged.
//   - Full with simultaneous pop and push: both happen, occupancy stays DEPTH, no drop.
//   - Empty with push: no pop possible that cycle; write only.
//   - Pointers are log2(DEPTH)+1 bits and wrap naturally.
//       full  = MSBs differ and LSBs are equal.
//       empty = pointers are equal.
//   - res_data/res_src show the head combinationally from storage (first-word fall-through).
//       They are stable while res_valid && !res_ready.
//   - fill_level is updated each edge: +1 on push only, -1 on pop only, unchanged on both/none.
//   - Counters hold at max and clear only on reset.
// CONFIGURATION
//   Macro ALU_RESULT_PARITY_EN:
//   - Defined: adds output res_parity (1 bit) = even parity (^data) of the head entry.
//       Parity is computed at push and stored alongside data; FIFO width grows by 1.
//       res_parity resets to 0.
//   - Undefined: the port and the stored bit do not exist; behaviour is otherwise identical.
// STRUCTURE
//   - Package alu_pkg:
//       source-ID localparams SRC_ARITH=2'd0, SRC_LOGIC=2'd1, SRC_CMP=2'd2, SRC_SHIFT=2'd3.
//       OUT_W derivation function.
//       Shared with the upstream units and the consumer.
//   - Sub-module alu_result_fifo:
//       generic synchronous FIFO with parameters WIDTH and DEPTH.
//       Ports push/pop/full/empty/count.
//   - Top level keeps the priority select, drop/collision counters and parity.
// TESTING
//   1. Reset: drive rst=0 mid-stream with 2 entries queued.
//      -> All outputs 0 immediately; after release res_valid stays 0.
//   2. Single push: Logic_Flag=1, Logic_OUT=32'h0000_00F0, res_ready=0.
//      -> Next cycle res_valid=1, res_data=32'hF0, res_src=1, fill_level=1.
//   3. Collision: Arith_Flag=1 (data 5) and SHIFT_Flag=1 (data 9) in the same cycle.
//      -> One entry: data 5, src 0; collision_cnt=1.
//   4. Overflow: DEPTH=4, res_ready=0, six consecutive CMP_Flag pulses.
//      -> fill_level=4, drop_cnt=2, head is the first pushed value.
//   5. Full push+pop: FIFO full, Logic_Flag=1 with res_ready=1 in the same cycle.
//      -> No drop, fill_level stays 4, order preserved.
//   6. Back-pressure: hold res_ready=0 for 3 cycles with res_valid=1.
//      -> res_data/res_src stable; ready=1 pops in FIFO order.
//      With ALU_RESULT_PARITY_EN: res_parity=^res_data.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: result source IDs and the result-width helper.
// Used by the upstream execution units, the result collector and the consumer.
package alu_pkg;

  localparam logic [1:0] SRC_ARITH = 2'd0;
  localparam logic [1:0] SRC_LOGIC = 2'd1;
  localparam logic [1:0] SRC_CMP   = 2'd2;
  localparam logic [1:0] SRC_SHIFT = 2'd3;

  function automatic int out_w(input int a_width, input int b_width);
    return a_width + b_width;
  endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// Generic first-word-fall-through FIFO with wrap-bit pointers.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module alu_result_fifo #(
  parameter  int WIDTH = 34,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
  assign rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

  // Head is forced to zero when empty so stale storage never leaks out after reset.
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/alu_result_collector.sv
// Collects one result per cycle from the ALU units (fixed priority), tags its source and queues it.
// Optional macro ALU_RESULT_PARITY_EN stores an even-parity bit per entry and exposes res_parity.
module alu_result_collector
  import alu_pkg::*;
#(
  parameter  int A_WIDTH    = 16,
  parameter  int B_WIDTH    = 16,
  parameter  int FIFO_DEPTH = 4,
  parameter  int CNT_WIDTH  = 8,
  localparam int OUT_W      = out_w(A_WIDTH, B_WIDTH),
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [OUT_W-1:0]     Arith_OUT,
  input  logic                 Arith_Flag,
  input  logic [OUT_W-1:0]     Logic_OUT,
  input  logic                 Logic_Flag,
  input  logic [OUT_W-1:0]     CMP_OUT,
  input  logic                 CMP_Flag,
  input  logic [OUT_W-1:0]     SHIFT_OUT,
  input  logic                 SHIFT_Flag,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [OUT_W-1:0]     res_data,
  output logic [1:0]           res_src,
  output logic [LVL_W-1:0]     fill_level,
`ifdef ALU_RESULT_PARITY_EN
  output logic                 res_parity,
`endif
  output logic [CNT_WIDTH-1:0] drop_cnt,
  output logic [CNT_WIDTH-1:0] collision_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;
`ifdef ALU_RESULT_PARITY_EN
  localparam int FW = OUT_W + 3;
`else
  localparam int FW = OUT_W + 2;
`endif

  logic [3:0]           flags;
  logic                 any_flag, multi_flag;
  logic [1:0]           sel_src;
  logic [OUT_W-1:0]     sel_data;
  logic                 fifo_full, fifo_empty;
  logic                 push, pop, drop;
  logic [FW-1:0]        fifo_wdata, fifo_rdata;
  logic [CNT_WIDTH-1:0] drop_q, drop_d, coll_q, coll_d;

  assign flags      = {Arith_Flag, Logic_Flag, CMP_Flag, SHIFT_Flag};
  assign any_flag   = |flags;
  assign multi_flag = ($countones(flags) > 1);

  always_comb begin
    sel_src  = SRC_SHIFT;
    sel_data = SHIFT_OUT;
    if (Arith_Flag) begin
      sel_src  = SRC_ARITH;
      sel_data = Arith_OUT;
    end else if (Logic_Flag) begin
      sel_src  = SRC_LOGIC;
      sel_data = Logic_OUT;
    end else if (CMP_Flag) begin
      sel_src  = SRC_CMP;
      sel_data = CMP_OUT;
    end
  end

  assign res_valid = !fifo_empty;
  assign pop       = res_valid && res_ready;
  // A full FIFO still takes the winner when the head leaves in the same cycle.
  assign push      = any_flag && (!fifo_full || pop);
  assign drop      = any_flag && fifo_full && !pop;

`ifdef ALU_RESULT_PARITY_EN
  assign fifo_wdata = {^sel_data, sel_src, sel_data};
  assign res_parity = fifo_rdata[OUT_W+2];
`else
  assign fifo_wdata = {sel_src, sel_data};
`endif
  assign res_data = fifo_rdata[OUT_W-1:0];
  assign res_src  = fifo_rdata[OUT_W+1:OUT_W];

  alu_result_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fill_level)
  );

  assign drop_d = (drop && (drop_q != '1)) ? drop_q + CNT_ONE : drop_q;
  assign coll_d = (multi_flag && (coll_q != '1)) ? coll_q + CNT_ONE : coll_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_q <= '0;
      coll_q <= '0;
    end else begin
      drop_q <= drop_d;
      coll_q <= coll_d;
    end
  end

  assign drop_cnt      = drop_q;
  assign collision_cnt = coll_q;

endmodule
